// File: rtl/conv_window_gen.sv
// ---------------------------------------------------------------------------
// conv_window_gen
//   Turns a raster-order pixel stream into KERNEL x KERNEL convolution
//   windows for the downstream PE MAC array. KERNEL-1 image lines are held
//   in line buffers, the most recent KERNEL-1 columns are held in a small
//   shift register, and one full window is produced per accepted pixel once
//   the window lies entirely inside the image. A one-deep output register
//   with valid/ready decouples the pixel side from the window side.
//
// Optional feature:
//   WIN_STRIDE2_EN  when defined, only windows whose top-left corner sits on
//                   an even row and an even column are emitted (stride 2).
//                   Other complete windows are dropped. m_last moves to the
//                   last window that is actually emitted.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  begin a frame (only looked at in IDLE)
//   cfg_width, cfg_height  frame size, latched on an accepted start
//   s_valid/s_ready/s_pixel  pixel input handshake, raster order
//   m_valid/m_ready        window output handshake
//   m_window               packed window, element (r,c) at
//                          [(r*KERNEL+c)*PIXEL_WIDTH +: PIXEL_WIDTH],
//                          r=0 oldest line, c=0 leftmost column
//   m_last                 marks the final window of the frame
//   busy                   frame in progress (state != IDLE)
//   frame_done             one-cycle pulse when the frame ends
//   cfg_err                one-cycle pulse when a start is rejected
// ---------------------------------------------------------------------------
module conv_window_gen #(
  parameter int PIXEL_WIDTH = 8,
  parameter int KERNEL      = 3,
  parameter int MAX_WIDTH   = 640,
  parameter int DIM_W       = 10
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [DIM_W-1:0]                      cfg_width,
  input  logic [DIM_W-1:0]                      cfg_height,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [PIXEL_WIDTH-1:0]                s_pixel,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [KERNEL*KERNEL*PIXEL_WIDTH-1:0]  m_window,
  output logic                                  m_last,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  cfg_err
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int WW = KERNEL * KERNEL * PIXEL_WIDTH;
  localparam int HW = KERNEL * (KERNEL - 1) * PIXEL_WIDTH;

  localparam logic [DIM_W-1:0] KERNEL_D = DIM_W'(KERNEL);
  localparam logic [DIM_W-1:0] KM1_D    = DIM_W'(KERNEL - 1);
  localparam logic [DIM_W-1:0] MAXW_D   = DIM_W'(MAX_WIDTH);
  localparam logic [DIM_W-1:0] ONE_D    = DIM_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [DIM_W-1:0] width_reg, height_reg;
  logic [DIM_W-1:0] col_reg, row_reg;
  logic [DIM_W-1:0] last_row_reg, last_col_reg;
  logic [DIM_W-1:0] last_row_cfg, last_col_cfg;
  logic [DIM_W-1:0] col_inc;

  logic cfg_ok;
  logic start_ok;
  logic accept;
  logic complete;
  logic emit;
  logic col_wrap;
  logic last_pixel;
  logic is_last_win;

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  assign cfg_ok   = (cfg_width >= KERNEL_D) && (cfg_width <= MAXW_D) &&
                    (cfg_height >= KERNEL_D);
  assign start_ok = (state_reg == IDLE) && start && cfg_ok;

  assign s_ready  = (state_reg == RUN) && (!m_valid || m_ready);
  assign accept   = s_valid && s_ready;
  assign busy     = (state_reg != IDLE);

  // Counters are the position of the pixel being accepted (pre-increment).
  assign complete   = (row_reg >= KM1_D) && (col_reg >= KM1_D);
  assign col_wrap   = (col_reg == width_reg - ONE_D);
  assign col_inc    = col_wrap ? '0 : col_reg + ONE_D;
  assign last_pixel = col_wrap && (row_reg == height_reg - ONE_D);
  assign is_last_win = (row_reg == last_row_reg) && (col_reg == last_col_reg);

`ifdef WIN_STRIDE2_EN
  localparam logic [DIM_W-1:0] TWO_D   = DIM_W'(2);
  localparam logic             KM1_LSB = KM1_D[0];

  // (row-(KERNEL-1)) is even exactly when row has the same parity as KERNEL-1.
  assign emit = complete && (row_reg[0] == KM1_LSB) && (col_reg[0] == KM1_LSB);

  // The last emitted window is the bottom-most/right-most one on the stride
  // grid; step back one line/column when the image edge is off-grid.
  always_comb begin
    last_row_cfg = cfg_height - ONE_D;
    last_col_cfg = cfg_width - ONE_D;
    if (cfg_height[0] == KM1_LSB) last_row_cfg = cfg_height - TWO_D;
    if (cfg_width[0] == KM1_LSB)  last_col_cfg = cfg_width - TWO_D;
  end
`else
  assign emit         = complete;
  assign last_row_cfg = cfg_height - ONE_D;
  assign last_col_cfg = cfg_width - ONE_D;
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (accept && last_pixel) state_next = FLUSH;
      // Leave as soon as the output register is empty or draining this cycle.
      FLUSH:   if (!m_valid || m_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Line buffers and column history
  // -------------------------------------------------------------------------
  // col_new[r] is the vertical slice of the image at the current column,
  // r=0 oldest line, r=KERNEL-1 the incoming pixel.
  logic [KERNEL-1:0][PIXEL_WIDTH-1:0] col_new;
  logic [AW-1:0]                      rd_addr;
  logic [AW-1:0]                      wr_addr;

  assign col_new[KERNEL-1] = s_pixel;
  assign wr_addr           = col_reg[AW-1:0];
  // The read is issued one cycle ahead so the registered read data always
  // holds the entry at the column of the next pixel to be accepted. The
  // write and read columns never collide because width >= 2.
  assign rd_addr           = accept ? col_inc[AW-1:0] : col_reg[AW-1:0];

  genvar gi, gj;
  generate
    for (gi = 0; gi < KERNEL - 1; gi++) begin : g_line
      logic [PIXEL_WIDTH-1:0] mem [MAX_WIDTH];
      logic [PIXEL_WIDTH-1:0] rd_q;

      // Each line shifts its column entry one line older on every accept.
      always_ff @(posedge clk) begin
        if (accept) mem[wr_addr] <= col_new[gi+1];
        rd_q <= mem[rd_addr];
      end

      assign col_new[gi] = rd_q;
    end
  endgenerate

  // hist holds the previous KERNEL-1 column slices; j=KERNEL-2 is newest.
  logic [HW-1:0] hist_reg;
  logic [WW-1:0] win_next;

  generate
    for (gi = 0; gi < KERNEL; gi++) begin : g_row
      for (gj = 0; gj < KERNEL; gj++) begin : g_col
        if (gj == KERNEL - 1) begin : g_new
          assign win_next[(gi*KERNEL+gj)*PIXEL_WIDTH +: PIXEL_WIDTH] = col_new[gi];
        end else begin : g_old
          assign win_next[(gi*KERNEL+gj)*PIXEL_WIDTH +: PIXEL_WIDTH] =
            hist_reg[(gi*(KERNEL-1)+gj)*PIXEL_WIDTH +: PIXEL_WIDTH];
          always_ff @(posedge clk) begin
            if (accept)
              hist_reg[(gi*(KERNEL-1)+gj)*PIXEL_WIDTH +: PIXEL_WIDTH] <=
                win_next[(gi*KERNEL+gj+1)*PIXEL_WIDTH +: PIXEL_WIDTH];
          end
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State, counters, output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      width_reg    <= '0;
      height_reg   <= '0;
      last_row_reg <= '0;
      last_col_reg <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_window     <= '0;
      frame_done   <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      frame_done <= (state_reg == FLUSH) && (state_next == IDLE);
      cfg_err    <= (state_reg == IDLE) && start && !cfg_ok;

      if (start_ok) begin
        width_reg    <= cfg_width;
        height_reg   <= cfg_height;
        last_row_reg <= last_row_cfg;
        last_col_reg <= last_col_cfg;
        col_reg      <= '0;
        row_reg      <= '0;
      end else if (accept) begin
        col_reg <= col_inc;
        if (col_wrap) row_reg <= row_reg + ONE_D;
      end

      // A new window may replace one being taken in the same cycle; while
      // the register is full and stalled, s_ready is low so nothing loads.
      if (accept && emit) begin
        m_valid  <= 1'b1;
        m_window <= win_next;
        m_last   <= is_last_win;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule
